// File: rtl/soundweb_stream_encoder.sv
// Soundweb stream encoder.
// Takes one parallel message body through a valid/ready handshake and emits
// it as a framed byte stream: STX, escaped body bytes, escaped XOR checksum
// (optional), ETX. All outputs come straight from flops; their next values
// are decoded from the next FSM state so the first STX appears one cycle
// after the message is accepted.
module soundweb_stream_encoder #(
  parameter int         BODY_BYTES  = 13,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter logic [7:0] STX         = 8'h02,
  parameter logic [7:0] ETX         = 8'h03,
  parameter logic [7:0] ESC         = 8'h1B
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*BODY_BYTES-1:0] in_body,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int                BODY_W   = 8 * BODY_BYTES;
  localparam int                IDX_W    = $clog2(BODY_BYTES) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BODY_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_STX  = 3'd1,
    SEND_BODY = 3'd2,
    SEND_ESC2 = 3'd3,
    SEND_CHK  = 3'd4,
    SEND_CHK2 = 3'd5,
    SEND_ETX  = 3'd6
  } state_e;

  // Bytes that collide with framing/control codes on the link.
  function automatic logic is_reserved(input logic [7:0] b);
    case (b)
      8'h02, 8'h03, 8'h06, 8'h15, 8'h1B: is_reserved = 1'b1;
      default:                           is_reserved = 1'b0;
    endcase
  endfunction

  // Second byte of an escape pair: original byte shifted into the upper half.
  function automatic logic [7:0] escaped(input logic [7:0] b);
    escaped = b + 8'h80;
  endfunction

  // Byte idx of a packed body; out-of-range indices read as zero.
  function automatic logic [7:0] body_byte(input logic [BODY_W-1:0] body,
                                           input logic [IDX_W-1:0]  idx);
    body_byte = 8'h00;
    for (int k = 0; k < BODY_BYTES; k++) begin
      body_byte = (idx == IDX_W'(k)) ? body[8*k +: 8] : body_byte;
    end
  endfunction

  // XOR of all raw body bytes; escape bytes never enter the checksum.
  function automatic logic [7:0] body_xor(input logic [BODY_W-1:0] body);
    body_xor = 8'h00;
    for (int k = 0; k < BODY_BYTES; k++) begin
      body_xor = body_xor ^ body[8*k +: 8];
    end
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [BODY_W-1:0] body_q, body_d;
  logic [7:0]        chk_q, chk_d;

  logic              in_ready_q, in_ready_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [7:0]        cur_byte_s;
  logic [7:0]        nxt_byte_s;
  state_e            after_body_s;

  assign cur_byte_s   = body_byte(body_q, index_q);
  assign nxt_byte_s   = body_byte(body_d, index_d);
  assign after_body_s = CHECKSUM_EN ? SEND_CHK : SEND_ETX;

  // State register: FSM state, captured body, byte index and checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      body_q  <= '0;
      chk_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      body_q  <= body_d;
      chk_q   <= chk_d;
    end
  end

  // Next-state logic: nothing advances while the current byte is not consumed.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    body_d  = body_q;
    chk_d   = chk_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = SEND_STX;
          body_d  = in_body;
          chk_d   = body_xor(in_body);
          index_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_STX: begin
        if (tx_ready) begin
          state_d = SEND_BODY;
          index_d = '0;
        end else begin
          state_d = SEND_STX;
        end
      end
      SEND_BODY: begin
        if (!tx_ready) begin
          state_d = SEND_BODY;
        end else if (is_reserved(cur_byte_s)) begin
          state_d = SEND_ESC2;
        end else if (index_q == LAST_IDX) begin
          state_d = after_body_s;
        end else begin
          index_d = index_q + IDX_W'(1);
        end
      end
      SEND_ESC2: begin
        if (!tx_ready) begin
          state_d = SEND_ESC2;
        end else if (index_q == LAST_IDX) begin
          state_d = after_body_s;
        end else begin
          state_d = SEND_BODY;
          index_d = index_q + IDX_W'(1);
        end
      end
      SEND_CHK: begin
        if (tx_ready) begin
          state_d = is_reserved(chk_q) ? SEND_CHK2 : SEND_ETX;
        end else begin
          state_d = SEND_CHK;
        end
      end
      SEND_CHK2: begin
        if (tx_ready) begin
          state_d = SEND_ETX;
        end else begin
          state_d = SEND_CHK2;
        end
      end
      SEND_ETX: begin
        if (tx_ready) begin
          state_d = IDLE;
        end else begin
          state_d = SEND_ETX;
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // Output decode from the next state so every output can be registered.
  always_comb begin
    in_ready_d   = 1'b0;
    tx_valid_d   = 1'b1;
    busy_d       = 1'b1;
    tx_data_d    = 8'h00;
    frame_done_d = (state_q == SEND_ETX) && tx_ready;
    case (state_d)
      IDLE: begin
        in_ready_d = 1'b1;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        tx_data_d  = 8'h00;
      end
      SEND_STX:  tx_data_d = STX;
      SEND_BODY: tx_data_d = is_reserved(nxt_byte_s) ? ESC : nxt_byte_s;
      SEND_ESC2: tx_data_d = escaped(nxt_byte_s);
      SEND_CHK:  tx_data_d = is_reserved(chk_d) ? ESC : chk_d;
      SEND_CHK2: tx_data_d = escaped(chk_d);
      SEND_ETX:  tx_data_d = ETX;
      default: begin
        in_ready_d = 1'b1;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q   <= 1'b1;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_soundweb_stream_encoder.sv
// Directed bench for soundweb_stream_encoder: default build plus a
// CHECKSUM_EN=0 build sharing the same stimulus.
module tb_soundweb_stream_encoder;

  logic         clk;
  logic         reset;
  logic [103:0] in_body;
  logic         in_valid;
  logic         tx_ready;

  logic         in_ready, tx_valid, busy, frame_done;
  logic [7:0]   tx_data;
  logic         in_ready2, tx_valid2, busy2, frame_done2;
  logic [7:0]   tx_data2;

  int checks;
  int errors;

  logic [7:0] got[$];
  logic [7:0] got2[$];

  soundweb_stream_encoder dut (
    .clk(clk), .reset(reset), .in_body(in_body), .in_valid(in_valid),
    .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done)
  );

  soundweb_stream_encoder #(.CHECKSUM_EN(1'b0)) dut_nochk (
    .clk(clk), .reset(reset), .in_body(in_body), .in_valid(in_valid),
    .in_ready(in_ready2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready), .busy(busy2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a message for exactly one accept edge.
  task automatic send_msg(input logic [103:0] body);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_body  = body;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("stx_latency1", {24'd0, tx_data}, 32'h02);
  endtask

  // Record consumed bytes until n have been taken (bounded), optionally
  // stalling 3 cycles on the first ESC, then check the frame_done cycle.
  task automatic collect(input int n, input bit stall_en);
    int  cyc;
    bit  stalled;
    cyc     = 0;
    stalled = 1'b0;
    got.delete();
    got2.delete();
    while (got.size() < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (stall_en && !stalled && tx_valid && tx_data == 8'h1B) begin
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          chk("stall_data_held", {24'd0, tx_data}, 32'h1B);
          chk("stall_valid_held", {31'd0, tx_valid}, 32'd1);
          @(negedge clk);
        end
        tx_ready = 1'b1;
        stalled  = 1'b1;
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (tx_valid2 && tx_ready) got2.push_back(tx_data2);
    end
    chk("frame_length", got.size(), n);
    @(posedge clk);
    #1;
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    chk("busy_after_etx", {31'd0, busy}, 32'd0);
    chk("in_ready_after_etx", {31'd0, in_ready}, 32'd1);
    chk("tx_valid_after_etx", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic compare(input string tag, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk(tag, {24'd0, got[i]}, {24'd0, exp[i]});
    end
  endtask

  // Bodies: byte 0 in bits [7:0].
  localparam logic [103:0] BODY_PLAIN = {8'h01, 88'h0, 8'h88};
  localparam logic [103:0] BODY_ESC   = {88'h0, 8'h02, 8'h88};
  localparam logic [103:0] BODY_CHKE  = {8'h9D, 88'h0, 8'h88};
  localparam logic [103:0] BODY_B     = {8'h20, 80'h0, 8'h06, 8'h10};

  logic [7:0] exp_plain[$];
  logic [7:0] exp_plain_nochk[$];
  logic [7:0] exp_esc[$];
  logic [7:0] exp_chke[$];
  logic [7:0] exp_b[$];

  initial begin
    checks = 0;
    errors = 0;
    exp_plain       = '{8'h02, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h89, 8'h03};
    exp_plain_nochk = '{8'h02, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
    exp_esc         = '{8'h02, 8'h88, 8'h1B, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h8A, 8'h03};
    exp_chke        = '{8'h02, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9D, 8'h1B, 8'h95, 8'h03};
    exp_b           = '{8'h02, 8'h10, 8'h1B, 8'h86, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h36, 8'h03};

    reset    = 1'b1;
    in_body  = '0;
    in_valid = 1'b0;
    tx_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Plain frame, both builds.
    send_msg(BODY_PLAIN);
    collect(16, 1'b0);
    compare("plain", exp_plain);
    chk("nochk_length", got2.size(), 15);
    for (int i = 0; i < 15; i++) begin
      if (i < got2.size()) chk("nochk", {24'd0, got2[i]}, {24'd0, exp_plain_nochk[i]});
    end
    @(posedge clk);
    #1;
    chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);

    // Escaped body byte.
    send_msg(BODY_ESC);
    collect(17, 1'b0);
    compare("esc_body", exp_esc);

    // Escaped checksum.
    send_msg(BODY_CHKE);
    collect(17, 1'b0);
    compare("esc_chk", exp_chke);

    // Backpressure on the ESC byte.
    send_msg(BODY_ESC);
    collect(17, 1'b1);
    compare("backpressure", exp_esc);

    // Reset mid-frame, then a clean frame.
    send_msg(BODY_ESC);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    send_msg(BODY_PLAIN);
    collect(16, 1'b0);
    compare("after_reset", exp_plain);

    // Back-to-back with in_valid held and in_body changing while busy.
    @(negedge clk);
    in_body  = BODY_PLAIN;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_body = BODY_B;
    chk("b2b_first_busy", {31'd0, busy}, 32'd1);
    collect(16, 1'b0);
    compare("b2b_first", exp_plain);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_second_stx", {24'd0, tx_data}, 32'h02);
    chk("b2b_second_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_cleared", {31'd0, frame_done}, 32'd0);
    collect(17, 1'b0);
    compare("b2b_second", exp_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
